gpio_bus_ctrl: RTL and testbench

GPIO_BUS_CTRL -- requirements
Module: gpio_bus_ctrl

---
 rtl/gpio_bus_ctrl.sv | 101 ++++++++++
 tb/tb_gpio_bus_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bus_ctrl.sv
// Memory-mapped GPIO controller: output register with buffer write pulse,
// synchronized and debounced inputs, rising-edge status and masked interrupt.
module gpio_bus_ctrl #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [7:0]  pin_in,
    output logic        gpio_write_en,
    output logic [7:0]  gpio_write_data,
    output logic        irq
);

    localparam logic [7:0] LP_LAST = 8'(DB_CYCLES - 1);

    logic [7:0] r_out;
    logic [7:0] r_s1;
    logic [7:0] r_s2;
    logic [7:0] r_deb;
    logic [7:0] r_cnt [8];
    logic [7:0] r_status;
    logic [7:0] r_mask;
    logic       r_wpulse;

    logic       w_wr;
    logic [7:0] w_clr;
    logic [7:0] w_flip;
    logic [7:0] w_rise;

    assign w_wr  = sel & we;
    assign w_clr = (w_wr && addr == 2'd2) ? wdata[7:0] : 8'h00;

    // A bit flips when it has disagreed with DEB for DB_CYCLES edges
    always_comb begin
        w_flip = 8'h00;
        for (int i = 0; i < 8; i++) begin
            w_flip[i] = (r_s2[i] != r_deb[i]) && (r_cnt[i] == LP_LAST);
        end
    end

    assign w_rise = w_flip & r_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out    <= 8'h00;
            r_s1     <= 8'h00;
            r_s2     <= 8'h00;
            r_deb    <= 8'h00;
            r_status <= 8'h00;
            r_mask   <= 8'h00;
            r_wpulse <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_cnt[i] <= 8'h00;
            end
        end else begin
            r_s1     <= pin_in;
            r_s2     <= r_s1;
            r_wpulse <= w_wr && addr == 2'd0;
            if (w_wr && addr == 2'd0) begin
                r_out <= wdata[7:0];
            end
            if (w_wr && addr == 2'd3) begin
                r_mask <= wdata[7:0];
            end
            // Set beats clear when both land on the same edge
            r_status <= (r_status & ~w_clr) | w_rise;
            for (int i = 0; i < 8; i++) begin
                if (r_s2[i] == r_deb[i]) begin
                    r_cnt[i] <= 8'h00;
                end else if (w_flip[i]) begin
                    r_deb[i] <= r_s2[i];
                    r_cnt[i] <= 8'h00;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (sel) begin
            case (addr)
                2'd0:    rdata = {24'h0, r_out};
                2'd1:    rdata = {24'h0, r_deb};
                2'd2:    rdata = {24'h0, r_status};
                default: rdata = {24'h0, r_mask};
            endcase
        end
    end

    assign gpio_write_en   = r_wpulse;
    assign gpio_write_data = r_out;
    assign irq             = |(r_status & r_mask);

endmodule

// File: tb/tb_gpio_bus_ctrl.sv
// Scoreboard bench for gpio_bus_ctrl: stimulus queues expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_gpio_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  pin_in;
    logic        gpio_write_en;
    logic [7:0]  gpio_write_data;
    logic        irq;

    always #5 clk = ~clk;

    gpio_bus_ctrl #(.DB_CYCLES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .sel             (sel),
        .we              (we),
        .addr            (addr),
        .wdata           (wdata),
        .rdata           (rdata),
        .pin_in          (pin_in),
        .gpio_write_en   (gpio_write_en),
        .gpio_write_data (gpio_write_data),
        .irq             (irq)
    );

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    logic [31:0] m_obs;
    int          errors = 0;
    int          checks = 0;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            m_e = q.pop_front();
            case (m_e.kind)
                0:       m_obs = rdata;
                1:       m_obs = {31'h0, irq};
                2:       m_obs = {31'h0, gpio_write_en};
                default: m_obs = {24'h0, gpio_write_data};
            endcase
            checks++;
            if (m_obs !== m_e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", m_e.name, m_obs, m_e.exp);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [31:0] v, input string n);
        exp_t e;
        e.kind = k;
        e.exp  = v;
        e.name = n;
        q.push_back(e);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] v, input string n);
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        push(0, v, n);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = {24'hC3A55A, d};
        tick();
        sel   = 1'b0;
        we    = 1'b0;
        wdata = 32'h0;
    endtask

    initial begin
        reset  = 1'b0;
        sel    = 1'b0;
        we     = 1'b0;
        addr   = 2'd0;
        wdata  = 32'h0;
        pin_in = 8'h00;
        tick();
        tick();
        push(0, 32'h0, "rst_rdata");
        push(1, 32'h0, "rst_irq");
        push(2, 32'h0, "rst_wen");
        push(3, 32'h0, "rst_wdata");
        tick();
        rd(2'd0, 32'h0, "rst_out");
        tick();
        reset = 1'b1;
        sel   = 1'b0;
        tick();

        // OUT write and single-cycle pulse
        wr(2'd0, 8'hA5);
        push(2, 32'h1, "wen_pulse");
        push(3, 32'hA5, "wdata_a5");
        rd(2'd0, 32'hA5, "out_rd");
        tick();
        sel = 1'b0;
        push(2, 32'h0, "wen_once");
        push(3, 32'hA5, "wdata_hold");
        tick();

        // back-to-back OUT writes
        sel   = 1'b1;
        we    = 1'b1;
        addr  = 2'd0;
        wdata = 32'hFFFF_FF11;
        tick();
        wdata = 32'hFFFF_FF22;
        push(2, 32'h1, "b2b_wen1");
        push(3, 32'h11, "b2b_d1");
        tick();
        we  = 1'b0;
        sel = 1'b0;
        push(2, 32'h1, "b2b_wen2");
        push(3, 32'h22, "b2b_d2");
        tick();
        push(2, 32'h0, "b2b_wen_end");
        tick();

        // debounce latency on bit 0
        pin_in = 8'h01;
        for (int n = 1; n <= 7; n++) begin
            tick();
            rd(2'd1, (n >= 6) ? 32'h1 : 32'h0, $sformatf("deb0_t%0d", n));
        end
        tick();
        rd(2'd2, 32'h1, "st_rise0");
        push(1, 32'h0, "irq_nomask");
        tick();
        wr(2'd3, 8'h01);
        push(1, 32'h1, "irq_mask0");
        tick();

        // glitch shorter than the debounce window
        wr(2'd2, 8'hFF);
        push(1, 32'h0, "irq_clr");
        rd(2'd2, 32'h0, "st_clr");
        tick();
        pin_in = 8'h09;
        tick();
        tick();
        pin_in = 8'h01;
        repeat (8) tick();
        rd(2'd1, 32'h1, "glitch_deb");
        tick();
        rd(2'd2, 32'h0, "glitch_st");
        push(1, 32'h0, "glitch_irq");
        tick();

        // falling edge sets nothing; build STATUS=0x81
        pin_in = 8'h00;
        repeat (8) tick();
        rd(2'd1, 32'h0, "deb_fall");
        tick();
        rd(2'd2, 32'h0, "fall_nost");
        tick();
        pin_in = 8'h81;
        repeat (7) tick();
        rd(2'd2, 32'h81, "st81");
        tick();
        rd(2'd2, 32'h81, "rd_noclr");
        tick();
        wr(2'd2, 8'h01);
        rd(2'd2, 32'h80, "w1c_bit0");
        tick();
        wr(2'd2, 8'h80);
        rd(2'd2, 32'h0, "w1c_bit7");
        tick();
        pin_in = 8'h01;
        repeat (8) tick();
        rd(2'd1, 32'h1, "deb7_fall");
        tick();

        // rise on bit 7 lands on the same edge as a clear of bit 7
        pin_in = 8'h81;
        repeat (5) tick();
        wr(2'd2, 8'h80);
        rd(2'd2, 32'h80, "set_wins");
        tick();

        // mask gating
        wr(2'd2, 8'hFF);
        wr(2'd3, 8'h00);
        pin_in = 8'h85;
        repeat (7) tick();
        rd(2'd2, 32'h4, "st04");
        push(1, 32'h0, "irq_masked");
        tick();
        wr(2'd3, 8'h04);
        push(1, 32'h1, "irq_unmask");
        rd(2'd3, 32'h4, "mask_rd");
        tick();
        wr(2'd1, 8'h00);
        rd(2'd1, 32'h85, "in_ro");
        tick();

        // reset mid-debounce and during the write pulse
        pin_in = 8'h95;
        repeat (3) tick();
        push(1, 32'h1, "pre_rst_irq");
        sel   = 1'b1;
        we    = 1'b1;
        addr  = 2'd0;
        wdata = 32'h0000_005A;
        tick();
        sel    = 1'b0;
        we     = 1'b0;
        #1;
        reset  = 1'b0;
        pin_in = 8'h00;
        push(2, 32'h0, "rst_wen_now");
        push(3, 32'h0, "rst_wdata_now");
        push(1, 32'h0, "rst_irq_now");
        rd(2'd3, 32'h0, "rst_mask_now");
        tick();
        tick();
        reset = 1'b1;
        sel   = 1'b0;
        repeat (8) tick();
        rd(2'd2, 32'h0, "post_st");
        push(2, 32'h0, "post_wen");
        push(1, 32'h0, "post_irq");
        push(3, 32'h0, "post_wdata");
        tick();
        rd(2'd0, 32'h0, "post_out");
        tick();
        rd(2'd1, 32'h0, "post_deb");
        tick();
        sel = 1'b0;
        tick();
        tick();

        if (q.size() != 0) begin
            $display("FAIL drain: got %0d pending expected 0", q.size());
            errors += q.size();
            checks += q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
